// File: rtl/neopixel_apb_ctrl.sv
// neopixel_apb_ctrl
// APB3 slave that owns the NeoPixel pixel byte buffer and the CTRL/STATUS registers.
// Buffer bytes go out over a valid/ready byte stream to the bit serializer. After the
// last byte the block holds a latch gap, then either goes idle or, in loop mode,
// restarts the frame.
// Register map: 0..BUFFER_BYTES-1 buffer, all-ones-minus-1 STATUS, all-ones CTRL.
// Optional feature: define NEOPIXEL_IRQ_EN to add the irq output and the stored CTRL[3] irqEn bit.
module neopixel_apb_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int BUFFER_BYTES = 60,
  parameter int WAIT_STATES  = 0,
  parameter int LATCH_CYCLES = 500
) (
  input  logic                  apbPclk,
  input  logic                  apbPresern,
  input  logic                  apbPselx,
  input  logic                  apbPenable,
  input  logic                  apbPwrite,
  input  logic [ADDR_WIDTH-1:0] apbPaddr,
  input  logic [7:0]            apbPwData,
  output logic [7:0]            apbPrData,
  output logic                  apbPready,
  output logic                  apbPslverr,
  output logic [7:0]            pixData,
  output logic                  pixValid,
  input  logic                  pixReady,
  output logic                  pixLast,
  output logic                  neoState
`ifdef NEOPIXEL_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int IDXW = (BUFFER_BYTES > 1) ? $clog2(BUFFER_BYTES) : 1;
  localparam int GAPW = $clog2(LATCH_CYCLES + 1);

  localparam logic [IDXW-1:0]       LAST_IDX    = IDXW'(BUFFER_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 2);
  localparam logic [ADDR_WIDTH-1:0] BUF_LIMIT   = ADDR_WIDTH'(BUFFER_BYTES);
  localparam logic [3:0]            WS_LAST     = 4'(WAIT_STATES);
  localparam logic [GAPW-1:0]       GAP_INIT    = GAPW'(LATCH_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_STREAM = 2'b01,
    ST_LATCH  = 2'b10
  } state_e;

  // APB decode
  logic            access_s;
  logic            ready_s;
  logic            in_buf_s;
  logic            is_ctrl_s;
  logic            is_status_s;
  logic            err_s;
  logic            wr_commit_s;
  logic            wr_buf_s;
  logic            wr_ctrl_s;
  logic            status_rd_s;
  logic [IDXW-1:0] wr_idx_s;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [7:0]      rd_mux_s;
  logic [7:0]      rdata_q, rdata_d;

  // Control bits
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic loop_q, loop_d;
  logic irqen_s;

  // Pixel buffer and streaming FSM
  logic [7:0]      buf_q [BUFFER_BYTES];
  logic [IDXW-1:0] fetch_idx_s;
  logic [7:0]      fetch_byte_s;
  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic [7:0]      pix_data_q, pix_data_d;
  logic            pix_valid_q, pix_valid_d;
  logic            pix_last_q, pix_last_d;
  logic            done_q, done_d;
  logic            stop_pend_q, stop_pend_d;
  logic            neo_state_q;

`ifdef NEOPIXEL_IRQ_EN
  logic irqen_q, irqen_d;
  logic irq_q;
  assign irqen_s = irqen_q;
  assign irq     = irq_q;
`else
  assign irqen_s = 1'b0;
`endif

  // Decode the APB access, address class, commit strobes and next wait count.
  always_comb begin
    access_s    = apbPselx & apbPenable;
    ready_s     = apbPresern & access_s & (wait_cnt_q == WS_LAST);
    in_buf_s    = (apbPaddr < BUF_LIMIT);
    is_ctrl_s   = (apbPaddr == CTRL_ADDR);
    is_status_s = (apbPaddr == STATUS_ADDR);
    if (apbPwrite) begin
      err_s = ~(in_buf_s | is_ctrl_s);
    end else begin
      err_s = ~(in_buf_s | is_status_s | is_ctrl_s);
    end
    wr_commit_s = ready_s & apbPwrite & ~err_s;
    wr_buf_s    = wr_commit_s & in_buf_s;
    wr_ctrl_s   = wr_commit_s & is_ctrl_s;
    status_rd_s = ready_s & ~apbPwrite & is_status_s;
    wr_idx_s    = IDXW'(apbPaddr);
    if (!access_s || ready_s) begin
      wait_cnt_d = 4'd0;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Read multiplexer; unmapped addresses read as zero.
  always_comb begin
    rd_mux_s = 8'h00;
    if (in_buf_s) begin
      rd_mux_s = buf_q[wr_idx_s];
    end else if (is_status_s) begin
      rd_mux_s = {6'b000000, done_q, neo_state_q};
    end else if (is_ctrl_s) begin
      rd_mux_s = {4'b0000, irqen_s, 1'b0, loop_q, 1'b0};
    end else begin
      rd_mux_s = 8'h00;
    end
    if (apbPselx && !apbPwrite) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = 8'h00;
    end
  end

  // Wait-state counter and registered read data.
  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      wait_cnt_q <= 4'd0;
      rdata_q    <= 8'h00;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign apbPready  = ready_s;
  assign apbPslverr = ready_s & err_s;
  assign apbPrData  = (ready_s && !apbPwrite) ? rdata_q : 8'h00;

  // CTRL next state: start/stop are one-cycle pulses, loop (and irqEn) are stored.
  always_comb begin
    start_d = wr_ctrl_s & apbPwData[0];
    stop_d  = wr_ctrl_s & apbPwData[2];
    if (wr_ctrl_s) begin
      loop_d = apbPwData[1];
    end else begin
      loop_d = loop_q;
    end
`ifdef NEOPIXEL_IRQ_EN
    if (wr_ctrl_s) begin
      irqen_d = apbPwData[3];
    end else begin
      irqen_d = irqen_q;
    end
`endif
  end

  // CTRL register.
  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      loop_q  <= 1'b0;
`ifdef NEOPIXEL_IRQ_EN
      irqen_q <= 1'b0;
`endif
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      loop_q  <= loop_d;
`ifdef NEOPIXEL_IRQ_EN
      irqen_q <= irqen_d;
`endif
    end
  end

  // Pixel buffer write port; the buffer contents survive reset.
  always_ff @(posedge apbPclk) begin
    if (wr_buf_s) begin
      buf_q[wr_idx_s] <= apbPwData;
    end
  end

  // Byte fetch for the next load, forwarding a same-cycle APB write to that byte.
  always_comb begin
    if ((state_q == ST_STREAM) && (idx_q < LAST_IDX)) begin
      fetch_idx_s = idx_q + IDXW'(1);
    end else begin
      fetch_idx_s = '0;
    end
    if (wr_buf_s && (wr_idx_s == fetch_idx_s)) begin
      fetch_byte_s = apbPwData;
    end else begin
      fetch_byte_s = buf_q[fetch_idx_s];
    end
  end

  // Streaming FSM next-state and output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    stop_pend_d = stop_pend_q;
    if (status_rd_s) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
    case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start_q) begin
          state_d     = ST_STREAM;
          idx_d       = '0;
          pix_data_d  = fetch_byte_s;
          pix_valid_d = 1'b1;
          pix_last_d  = (LAST_IDX == '0);
        end else begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
        end
      end
      ST_STREAM: begin
        if (stop_q) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        if (pix_valid_q && pixReady) begin
          if ((idx_q < LAST_IDX) && !stop_pend_q && !stop_q) begin
            idx_d       = fetch_idx_s;
            pix_data_d  = fetch_byte_s;
            pix_valid_d = 1'b1;
            pix_last_d  = (fetch_idx_s == LAST_IDX);
          end else begin
            state_d     = ST_LATCH;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            gap_d       = GAP_INIT;
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_LATCH: begin
        if (stop_q) begin
          stop_pend_d = 1'b1;
        end else begin
          stop_pend_d = stop_pend_q;
        end
        if (gap_q <= GAPW'(1)) begin
          if (loop_q && !stop_pend_q && !stop_q) begin
            state_d     = ST_STREAM;
            idx_d       = '0;
            pix_data_d  = fetch_byte_s;
            pix_valid_d = 1'b1;
            pix_last_d  = (LAST_IDX == '0);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q - GAPW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        pix_valid_d = 1'b0;
        pix_last_d  = 1'b0;
      end
    endcase
  end

  // Streaming FSM state and registered pixel outputs.
  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      gap_q       <= '0;
      pix_data_q  <= 8'h00;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      neo_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_last_q  <= pix_last_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
      neo_state_q <= (state_d != ST_IDLE);
    end
  end

`ifdef NEOPIXEL_IRQ_EN
  // Interrupt follows the sticky done flag when enabled.
  always_ff @(posedge apbPclk) begin
    if (!apbPresern) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_d & irqen_d;
    end
  end
`endif

  assign pixData  = pix_data_q;
  assign pixValid = pix_valid_q;
  assign pixLast  = pix_last_q;
  assign neoState = neo_state_q;

endmodule
